// File: rtl/seq_magnitude_compare_pkg.sv
// Shared types and helpers for the GCD datapath comparator.
// Holds the controller state type, the one-hot compare result and chunk-count helper.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_result_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/seq_magnitude_compare_chunk_compare.sv
// Combinational unsigned magnitude compare of one CHUNK-bit slice.
// Exactly one of gt/eq/lt is high for any input pair.
module chunk_compare #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/seq_magnitude_compare.sv
// Multi-cycle magnitude comparator: scans operands CHUNK bits per cycle, MSB first,
// stopping on the first differing chunk; result held under a valid/ready handshake.
module seq_magnitude_compare
  import gcd_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int CHUNK  = 4,
  localparam int NCHUNK = nchunk(WIDTH, CHUNK),
  localparam int CW     = $clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             signed_mode,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CW-1:0]    cycles
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SCAN = SCAN;
  localparam logic [1:0] ST_HOLD = HOLD;

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [CW-1:0]    cycles_reg, cycles_next;
  cmp_result_t      res_reg, res_next;

  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];
  logic             c_gt, c_eq, c_lt;

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // A single slice comparator is time-shared across chunks via idx.
  chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
    .a  (a_chunk[idx_reg]),
    .b  (b_chunk[idx_reg]),
    .gt (c_gt),
    .eq (c_eq),
    .lt (c_lt)
  );

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    idx_next    = idx_reg;
    cycles_next = cycles_reg;
    res_next    = res_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_valid) begin
          a_next = data1;
          b_next = data2;
          // Flipping both sign bits maps two's-complement order onto unsigned order.
          if (signed_mode) begin
            a_next[WIDTH-1] = ~data1[WIDTH-1];
            b_next[WIDTH-1] = ~data2[WIDTH-1];
          end
          idx_next    = IW'(NCHUNK - 1);
          cycles_next = '0;
          res_next    = '0;
          state_next  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        cycles_next = cycles_reg + CW'(1);
        if (!c_eq) begin
          res_next.gt = c_gt;
          res_next.lt = c_lt;
          state_next  = ST_HOLD;
        end else if (idx_reg == '0) begin
          res_next.eq = 1'b1;
          state_next  = ST_HOLD;
        end else begin
          idx_next = idx_reg - IW'(1);
        end
      end
      ST_HOLD: begin
        if (done_ready) begin
          res_next    = '0;
          cycles_next = '0;
          idx_next    = '0;
          state_next  = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      idx_reg    <= '0;
      cycles_reg <= '0;
      res_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      idx_reg    <= idx_next;
      cycles_reg <= cycles_next;
      res_reg    <= res_next;
    end
  end

  assign start_ready = (state_reg == ST_IDLE);
  assign done_valid  = (state_reg == ST_HOLD);
  assign gt          = res_reg.gt;
  assign eq          = res_reg.eq;
  assign lt          = res_reg.lt;
  assign cycles      = cycles_reg;

endmodule
